btb_predictor: RTL
==================

# btb_predictor

Parametrised branch target buffer (BTB) with 2-bit saturating-counter direction prediction for the 5-stage MIPS pipeline. It is looked up in IF with the fetch PC and updated from EX with the resolved outcome of each control-transfer instruction. On a misprediction it produces the redirect target and the flush request. It replaces the always-not-taken/flush-on-taken policy with a predicted-fetch policy.

## Interface
- XLEN, 32, address/data width
- ENTRIES, 16, BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- TAG_W, 8, tag bits stored per entry; IDX_W+2+TAG_W ≤ XLEN
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_pc  in  XLEN  fetch PC
- if_hit  out  1  valid entry with matching tag
- if_pred_taken  out  1  if_hit & counter[1]
- if_pred_target  out  XLEN  stored target; 0 when !if_hit
- ex_valid  in  1  EX holds a real (not flushed) control transfer
- ex_pc  in  XLEN  PC of that instruction
- ex_pred_taken  in  1  prediction carried down from IF
- ex_pred_target  in  XLEN  predicted target carried down from IF
- ex_taken  in  1  actual direction
- ex_target  in  XLEN  actual target (branch or jr)
- redirect  out  1  misprediction; PC must load redirect_pc
- redirect_pc  out  XLEN  corrected fetch PC
- flush  out  1  kill the IF/ID and ID/EX contents; equals redirect

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry fields: valid, tag, target, cnt[1:0]. Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup is combinational from registered table state. It is a hit when valid and the tag matches.
- Mispredict = ex_valid & ((ex_pred_taken ≠ ex_taken) | (ex_taken & ex_pred_target ≠ ex_target)).
- redirect_pc = ex_taken ? ex_target : ex_pc+4, with mod 2^XLEN wrap. redirect_pc is 0 when redirect=0.
- Update on a clock edge when ex_valid:
  - Hit at ex_pc: cnt += 1 on taken, saturating at 11. cnt −= 1 on not-taken, saturating at 00. When taken, the target is overwritten with ex_target.
  - Miss and taken: the entry is allocated or replaced (valid=1, tag, target, cnt=10).
  - Miss and not-taken: the table is unchanged.
- ex_valid=0 leaves the table and the statistics unchanged, and forces redirect=0.

## Timing
- Lookup: 0-cycle latency, combinational from if_pc.
- redirect, redirect_pc and flush are combinational in the same cycle as ex_valid. The PC loads redirect_pc at the next edge.
- Table writes are visible to lookups from the cycle after the update edge.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents (no bypass).
- Reset (asynchronous, any time, including mid-update): every valid bit is cleared and every cnt is set to 01. Tags and targets are don't-care. All outputs then read 0 while ex_valid=0 and no entry is valid.
- There is no stall input. The pipeline holds ex_valid low during stalls so that no update is double-counted.

## Configuration
- BTB_STATS_EN defined: adds three outputs, each XLEN wide and reset to 0:
  - stat_branches: increments for each ex_valid cycle.
  - stat_mispred: increments for each redirect cycle.
  - stat_hits: increments for each ex_valid cycle with ex_pred_taken=1.
  - All three wrap at 2^XLEN.
- BTB_STATS_EN undefined: the ports and counters are absent. Prediction behaviour is identical in both builds.

## Structure
- Package btb_pkg holds:
  - the counter-encoding constants CNT_SNT, CNT_WNT, CNT_WT, CNT_ST;
  - CNT_ALLOC (= CNT_WT) and CNT_RESET (= CNT_WNT);
  - the entry struct type.
- Sub-module sat_counter2 is the combinational 2-bit saturating next-state function (cnt, taken -> cnt_next). It is instantiated once in the update path.
- Storage is register arrays, not SRAM, so that the asynchronous reset and the combinational read hold.

## Test plan
Defaults ENTRIES=16, TAG_W=8:
- **Cold lookup.** Reset, then if_pc=0x40 -> if_hit=0, if_pred_taken=0, if_pred_target=0.
- **Allocate on taken miss.** ex_valid, ex_pc=0x40, ex_taken=1, ex_target=0x100, ex_pred_taken=0 -> redirect=1, redirect_pc=0x100, flush=1. Next cycle, if_pc=0x40 -> hit=1, pred_taken=1, target=0x100.
- **Counter walk.** Resolve 0x40 taken, then not-taken twice -> cnt goes 11 then 10 then 01. if_pred_taken=0 after the second not-taken. With ex_pred_taken=1, ex_taken=0, redirect_pc=0x44.
- **Aliasing.** 0x40 is resident; if_pc=0x440 (same index, different tag) -> hit=0. A taken resolve at 0x440 with target 0x200 replaces the entry; 0x40 then misses.
- **Same-cycle read/update.** if_pc=ex_pc=0x40 while the update writes target 0x300 -> if_pred_target still shows the old 0x100 that cycle and 0x300 the next cycle.
- **Reset mid-run, BTB_STATS_EN build.** After 5 branches with 2 mispredicts, the stats read 5/2/x. Assert reset mid-cycle -> all stats read 0 and the 0x40 lookup misses.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: 2-bit counter encodings
// and the per-entry storage record.
package btb_pkg;

    localparam int unsigned BTB_XLEN  = 32;
    localparam int unsigned BTB_TAG_W = 8;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    localparam logic [1:0] CNT_ALLOC = CNT_WT;
    localparam logic [1:0] CNT_RESET = CNT_WNT;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_XLEN-1:0]  target;
        logic [1:0]           cnt;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import btb_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Branch target buffer with 2-bit direction counters: IF lookup, EX update and
// mispredict redirect. Define BTB_STATS_EN to add the branch statistics outputs.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int unsigned XLEN    = BTB_XLEN,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = BTB_TAG_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_hit,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
`ifdef BTB_STATS_EN
    ,
    output logic [XLEN-1:0] stat_branches,
    output logic [XLEN-1:0] stat_mispred,
    output logic [XLEN-1:0] stat_hits
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

    // The entry record is sized by the package, so the widths must agree.
    if (XLEN != BTB_XLEN || TAG_W != BTB_TAG_W) begin : g_width_check
        $error("btb_predictor: XLEN/TAG_W must match btb_pkg entry widths");
    end

    btb_entry_t table_q [ENTRIES];
    btb_entry_t table_d [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    btb_entry_t       if_entry, ex_entry;
    logic             ex_hit;
    logic [1:0]       cnt_next;
    logic             mispredict;

    assign if_idx   = if_pc[IDX_W+1:2];
    assign if_tag   = if_pc[TAG_HI:TAG_LO];
    assign ex_idx   = ex_pc[IDX_W+1:2];
    assign ex_tag   = ex_pc[TAG_HI:TAG_LO];
    assign if_entry = table_q[if_idx];
    assign ex_entry = table_q[ex_idx];

    logic unused_if_lo;
    assign unused_if_lo = ^if_pc[1:0];
    if (TAG_HI + 1 < XLEN) begin : g_unused_hi
        logic unused_if_hi;
        assign unused_if_hi = ^if_pc[XLEN-1:TAG_HI+1];
    end

    always_comb begin
        if_hit         = if_entry.valid && (if_entry.tag == if_tag);
        if_pred_taken  = if_hit && if_entry.cnt[1];
        if_pred_target = if_hit ? if_entry.target : '0;
    end

    always_comb begin
        mispredict  = ex_valid && ((ex_pred_taken != ex_taken) ||
                                   (ex_taken && (ex_pred_target != ex_target)));
        redirect    = mispredict;
        flush       = mispredict;
        redirect_pc = '0;
        if (mispredict) redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
    end

    assign ex_hit = ex_entry.valid && (ex_entry.tag == ex_tag);

    sat_counter2 u_sat_counter2 (
        .cnt      (ex_entry.cnt),
        .taken    (ex_taken),
        .cnt_next (cnt_next)
    );

    // A not-taken miss leaves the table alone; a taken miss allocates over any alias.
    always_comb begin
        table_d = table_q;
        if (ex_valid) begin
            if (ex_hit) begin
                table_d[ex_idx].cnt = cnt_next;
                if (ex_taken) table_d[ex_idx].target = ex_target;
            end else if (ex_taken) begin
                table_d[ex_idx].valid  = 1'b1;
                table_d[ex_idx].tag    = ex_tag;
                table_d[ex_idx].target = ex_target;
                table_d[ex_idx].cnt    = CNT_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_RESET};
            end
        end else begin
            table_q <= table_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [XLEN-1:0] stat_branches_q, stat_branches_d;
    logic [XLEN-1:0] stat_mispred_q,  stat_mispred_d;
    logic [XLEN-1:0] stat_hits_q,     stat_hits_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        stat_hits_d     = stat_hits_q;
        if (ex_valid) stat_branches_d = stat_branches_q + XLEN'(1);
        if (mispredict) stat_mispred_d = stat_mispred_q + XLEN'(1);
        if (ex_valid && ex_pred_taken) stat_hits_d = stat_hits_q + XLEN'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
            stat_hits_q     <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
            stat_hits_q     <= stat_hits_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
    assign stat_hits     = stat_hits_q;
`endif

endmodule
